spi_transmitter: RTL and testbench

- SPI slave transmitter: serialises a parallel word onto sdo (MISO), clocked by an external master's ss/sclk.
- Counterpart of spi_receiver. Uses the same parameter set and semantics, so a receiver/transmitter pair with identical parameters interoperates on one bus.
- Oversamples ss and sclk with the system clock.
- Offers a one-word holding buffer with a ready/load handshake toward local logic.

---
 rtl/spi_transmitter.sv | 249 ++++++++++++++++++++++++
 tb/tb_spi_transmitter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_transmitter.sv
// SPI slave transmitter: oversamples ss/sclk on the system clock and shifts a
// buffered parallel word out on sdo, with a one-word holding register.
module spi_transmitter #(
  parameter bit ss_polarity   = 1'b1,
  parameter bit sclk_polarity = 1'b0,
  parameter bit sclk_phase    = 1'b0,
  parameter int bitcount      = 7,
  parameter bit msb_first     = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ss,
  input  logic              sclk,
  input  logic [bitcount:0] data,
  input  logic              load,
  output logic              ready,
  output logic              sdo,
  output logic              sdo_enable,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              aborted
);
  localparam int cnt_w = (bitcount > 0) ? $clog2(bitcount + 1) : 1;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(bitcount);
  localparam logic [cnt_w-1:0] cnt_zero = {cnt_w{1'b0}};
  localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);
  localparam logic [bitcount:0] word_zero = {(bitcount + 1){1'b0}};

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state_r, state_nxt_s;
  logic              ss_meta_r, ss_sync_r, ss_prev_r;
  logic              sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic [bitcount:0] hold_r, hold_nxt_s, shift_r, shift_nxt_s, word_s;
  logic [cnt_w-1:0]  cnt_r, cnt_nxt_s;
  logic              ready_r, ready_nxt_s, wait_r, wait_nxt_s, seen_r, seen_nxt_s;
  logic              busy_r, busy_nxt_s, sdo_r, sdo_nxt_s, en_r, en_nxt_s;
  logic              done_r, done_nxt_s, under_r, under_nxt_s, abort_r, abort_nxt_s;
  logic              ss_act_s, ss_rise_s, lead_s, trail_s, sample_s, shift_e_s;
  logic              start_s, zero_start_s;

  // Bit of word w that goes out in position n of the serial frame.
  function automatic logic bit_at(input logic [bitcount:0] w, input logic [cnt_w-1:0] n);
    logic [cnt_w-1:0] idx;
    idx = msb_first ? (last_cnt - n) : n;
    return w[idx];
  endfunction

  // Two-stage synchronisers plus a history stage for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ss_meta_r   <= ~ss_polarity;
      ss_sync_r   <= ~ss_polarity;
      ss_prev_r   <= ~ss_polarity;
      sclk_meta_r <= sclk_polarity;
      sclk_sync_r <= sclk_polarity;
      sclk_prev_r <= sclk_polarity;
    end else begin
      ss_meta_r   <= ss;
      ss_sync_r   <= ss_meta_r;
      ss_prev_r   <= ss_sync_r;
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
    end
  end

  assign ss_act_s  = (ss_sync_r == ss_polarity);
  assign ss_rise_s = ss_act_s && (ss_prev_r != ss_polarity);
  assign lead_s    = (sclk_prev_r == sclk_polarity) && (sclk_sync_r != sclk_polarity);
  assign trail_s   = (sclk_prev_r != sclk_polarity) && (sclk_sync_r == sclk_polarity);
  assign sample_s  = sclk_phase ? trail_s : lead_s;
  assign shift_e_s = sclk_phase ? lead_s : trail_s;

  // Next-state, holding-register and output decode.
  always_comb begin
    state_nxt_s  = state_r;
    hold_nxt_s   = hold_r;
    ready_nxt_s  = ready_r;
    shift_nxt_s  = shift_r;
    cnt_nxt_s    = cnt_r;
    wait_nxt_s   = wait_r;
    seen_nxt_s   = seen_r;
    busy_nxt_s   = busy_r;
    sdo_nxt_s    = sdo_r;
    en_nxt_s     = en_r;
    done_nxt_s   = 1'b0;
    under_nxt_s  = 1'b0;
    abort_nxt_s  = 1'b0;
    start_s      = 1'b0;
    zero_start_s = 1'b0;
    word_s       = word_zero;

    if (load && ready_r) begin
      hold_nxt_s  = data;
      ready_nxt_s = 1'b0;
    end else begin
      hold_nxt_s  = hold_r;
    end

    case (state_r)
      IDLE: begin
        sdo_nxt_s  = 1'b0;
        en_nxt_s   = 1'b0;
        busy_nxt_s = 1'b0;
        cnt_nxt_s  = cnt_zero;
        seen_nxt_s = 1'b0;
        wait_nxt_s = 1'b0;
        if (ss_rise_s) begin
          state_nxt_s = SHIFT;
          en_nxt_s    = 1'b1;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (!ss_act_s) begin
          state_nxt_s = IDLE;
          en_nxt_s    = 1'b0;
          sdo_nxt_s   = 1'b0;
          busy_nxt_s  = 1'b0;
          cnt_nxt_s   = cnt_zero;
          seen_nxt_s  = 1'b0;
          wait_nxt_s  = 1'b0;
          shift_nxt_s = word_zero;
          if (busy_r && sample_s && (cnt_r == last_cnt)) begin
            done_nxt_s  = 1'b1;
          end else if (busy_r && ((cnt_r != cnt_zero) || seen_r || sample_s || shift_e_s)) begin
            abort_nxt_s = 1'b1;
          end else begin
            abort_nxt_s = 1'b0;
          end
        end else if (busy_r) begin
          if (sample_s) begin
            seen_nxt_s = 1'b1;
            if (cnt_r == last_cnt) begin
              done_nxt_s = 1'b1;
              busy_nxt_s = 1'b0;
              wait_nxt_s = 1'b1;
              cnt_nxt_s  = cnt_zero;
            end else begin
              cnt_nxt_s  = cnt_r + cnt_one;
            end
          end else if (shift_e_s) begin
            seen_nxt_s = 1'b1;
            sdo_nxt_s  = bit_at(shift_r, cnt_r);
          end else begin
            seen_nxt_s = seen_r;
          end
        end else if (wait_r) begin
          // With CPHA=0 an empty buffer defers the next word to the master's first sample.
          if (shift_e_s && (sclk_phase || !ready_r || load)) begin
            start_s = 1'b1;
          end else if (sample_s) begin
            start_s      = 1'b1;
            zero_start_s = 1'b1;
          end else begin
            start_s = 1'b0;
          end
        end else begin
          wait_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        en_nxt_s    = 1'b0;
        sdo_nxt_s   = 1'b0;
        busy_nxt_s  = 1'b0;
      end
    endcase

    if (start_s) begin
      if (zero_start_s) begin
        word_s      = word_zero;
        under_nxt_s = 1'b1;
      end else if (!ready_r) begin
        word_s      = hold_r;
        ready_nxt_s = 1'b1;
      end else if (load) begin
        word_s      = data;
        ready_nxt_s = 1'b1;
        hold_nxt_s  = hold_r;
      end else begin
        word_s      = word_zero;
        under_nxt_s = 1'b1;
      end
      shift_nxt_s = word_s;
      busy_nxt_s  = 1'b1;
      wait_nxt_s  = 1'b0;
      seen_nxt_s  = shift_e_s | sample_s;
      sdo_nxt_s   = bit_at(word_s, cnt_zero);
      cnt_nxt_s   = cnt_zero;
      if (zero_start_s && (last_cnt == cnt_zero)) begin
        done_nxt_s = 1'b1;
        busy_nxt_s = 1'b0;
        wait_nxt_s = 1'b1;
      end else if (zero_start_s) begin
        cnt_nxt_s  = cnt_one;
      end else begin
        cnt_nxt_s  = cnt_zero;
      end
    end else begin
      word_s = word_zero;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      hold_r  <= word_zero;
      shift_r <= word_zero;
      cnt_r   <= cnt_zero;
      ready_r <= 1'b1;
      wait_r  <= 1'b0;
      seen_r  <= 1'b0;
      busy_r  <= 1'b0;
      sdo_r   <= 1'b0;
      en_r    <= 1'b0;
      done_r  <= 1'b0;
      under_r <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      hold_r  <= hold_nxt_s;
      shift_r <= shift_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= ready_nxt_s;
      wait_r  <= wait_nxt_s;
      seen_r  <= seen_nxt_s;
      busy_r  <= busy_nxt_s;
      sdo_r   <= sdo_nxt_s;
      en_r    <= en_nxt_s;
      done_r  <= done_nxt_s;
      under_r <= under_nxt_s;
      abort_r <= abort_nxt_s;
    end
  end

  assign ready      = ready_r;
  assign sdo        = sdo_r;
  assign sdo_enable = en_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign underrun   = under_r;
  assign aborted    = abort_r;
endmodule

// File: tb/tb_spi_transmitter.sv
// Bench for spi_transmitter: a behavioural SPI master drives two instances
// (CPHA=0/MSB-first and CPHA=1/LSB-first) and compares sampled frames to the word order model.
module tb_spi_transmitter;
  localparam int HALF = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ss_v   [2];
  logic       sclk_v [2];
  logic [7:0] data_v [2];
  logic       load_v [2];
  logic       ready_v [2], sdo_v [2], en_v [2], busy_v [2];
  logic       done_v [2], und_v [2], abt_v [2];

  int tests_run = 0;
  int failures  = 0;
  int done_cnt [2] = '{0, 0};
  int und_cnt  [2] = '{0, 0};
  int abt_cnt  [2] = '{0, 0};

  always #5 clock = ~clock;

  spi_transmitter u0 (
    .clock(clock), .reset_n(reset_n), .ss(ss_v[0]), .sclk(sclk_v[0]), .data(data_v[0]),
    .load(load_v[0]), .ready(ready_v[0]), .sdo(sdo_v[0]), .sdo_enable(en_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .underrun(und_v[0]), .aborted(abt_v[0]));

  spi_transmitter #(.sclk_phase(1'b1), .msb_first(1'b0)) u1 (
    .clock(clock), .reset_n(reset_n), .ss(ss_v[1]), .sclk(sclk_v[1]), .data(data_v[1]),
    .load(load_v[1]), .ready(ready_v[1]), .sdo(sdo_v[1]), .sdo_enable(en_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .underrun(und_v[1]), .aborted(abt_v[1]));

  // Pulse counters, sampled on the inactive edge.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (done_v[k] === 1'b1) done_cnt[k]++;
      if (und_v[k] === 1'b1) und_cnt[k]++;
      if (abt_v[k] === 1'b1) abt_cnt[k]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Order in which the master sees the bits of w: element i is the i-th sampled bit.
  function automatic logic [7:0] exp_seq(input logic [7:0] w, input bit msb);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = msb ? w[7 - i] : w[i];
    return s;
  endfunction

  task automatic load_word(input int u, input logic [7:0] w);
    data_v[u] = w;
    load_v[u] = 1'b1;
    hold(1);
    load_v[u] = 1'b0;
  endtask

  task automatic ss_on(input int u);
    ss_v[u] = 1'b1;
    hold(5);
  endtask

  task automatic ss_off(input int u);
    ss_v[u] = 1'b0;
    hold(5);
  endtask

  // Master clocking: instance 0 samples on leading edges, instance 1 on trailing edges.
  task automatic pulses(input int u, input int n, output logic [15:0] got);
    got = 16'h0000;
    for (int i = 0; i < n; i++) begin
      sclk_v[u] = 1'b1;
      if (u == 0) got[i] = sdo_v[u];
      hold(HALF);
      sclk_v[u] = 1'b0;
      if (u == 1) got[i] = sdo_v[u];
      hold(HALF);
    end
  endtask

  initial begin
    logic [15:0] got, got2;
    logic [7:0]  w1, w2;
    int d0, u0c, a0c;
    for (int k = 0; k < 2; k++) begin
      ss_v[k] = 1'b0; sclk_v[k] = 1'b0; data_v[k] = 8'h00; load_v[k] = 1'b0;
    end
    hold(3);
    check("rst_ready", ready_v[0], 1'b1);
    check("rst_outs", {sdo_v[0], en_v[0], busy_v[0], done_v[0], und_v[0], abt_v[0]}, 6'b000000);
    reset_n = 1'b1;
    hold(3);

    // 1: CPHA=0 MSB-first word 0xA5
    d0 = done_cnt[0]; u0c = und_cnt[0];
    load_word(0, 8'hA5);
    check("t1_ready_full", ready_v[0], 1'b0);
    ss_on(0);
    check("t1_ready_start", ready_v[0], 1'b1);
    check("t1_enable", {en_v[0], busy_v[0]}, 2'b11);
    pulses(0, 8, got);
    ss_off(0);
    check("t1_seq", got[7:0], exp_seq(8'hA5, 1'b1));
    check("t1_done", done_cnt[0] - d0, 1);
    check("t1_underrun", und_cnt[0] - u0c, 0);
    check("t1_idle", {en_v[0], sdo_v[0], busy_v[0]}, 3'b000);

    // 2: CPHA=1 LSB-first word 0xC1
    d0 = done_cnt[1];
    load_word(1, 8'hC1);
    ss_on(1);
    pulses(1, 8, got);
    ss_off(1);
    check("t2_seq", got[7:0], exp_seq(8'hC1, 1'b0));
    check("t2_seq_lit", got[7:0], 8'b1100_0001);
    check("t2_done", done_cnt[1] - d0, 1);

    // 3: no word loaded
    d0 = done_cnt[0]; u0c = und_cnt[0];
    ss_on(0);
    check("t3_underrun", und_cnt[0] - u0c, 1);
    pulses(0, 8, got);
    ss_off(0);
    check("t3_seq", got[7:0], 8'h00);
    check("t3_done", done_cnt[0] - d0, 1);

    // 4: two words streamed; a load while full is ignored
    d0 = done_cnt[0]; u0c = und_cnt[0]; a0c = abt_cnt[0];
    load_word(0, 8'h12);
    ss_on(0);
    pulses(0, 2, got);
    load_word(0, 8'h34);
    check("t4_ready_full", ready_v[0], 1'b0);
    load_word(0, 8'h56);
    pulses(0, 14, got2);
    ss_off(0);
    got = {got2[13:0], got[1:0]};
    check("t4_word1", got[7:0], exp_seq(8'h12, 1'b1));
    check("t4_word2", got[15:8], exp_seq(8'h34, 1'b1));
    check("t4_done", done_cnt[0] - d0, 2);
    check("t4_no_underrun", und_cnt[0] - u0c, 0);
    check("t4_no_abort", abt_cnt[0] - a0c, 0);
    check("t4_ready_end", ready_v[0], 1'b1);

    // 5: abort after three bits, then a clean 0x0F
    d0 = done_cnt[0]; a0c = abt_cnt[0];
    load_word(0, 8'hFF);
    ss_on(0);
    pulses(0, 3, got);
    check("t5_busy", {en_v[0], busy_v[0]}, 2'b11);
    ss_v[0] = 1'b0;
    hold(3);
    check("t5_enable_off", {en_v[0], busy_v[0]}, 2'b00);
    hold(3);
    check("t5_aborted", abt_cnt[0] - a0c, 1);
    check("t5_no_done", done_cnt[0] - d0, 0);
    load_word(0, 8'h0F);
    ss_on(0);
    pulses(0, 8, got);
    ss_off(0);
    check("t5_next_seq", got[7:0], 8'b1111_0000);

    // 6: reset in the middle of a word
    load_word(0, 8'h3C);
    ss_on(0);
    pulses(0, 3, got);
    reset_n = 1'b0;
    ss_v[0] = 1'b0;
    #1;
    check("t6_rst_outs", {sdo_v[0], en_v[0], busy_v[0], done_v[0], und_v[0], abt_v[0]}, 6'b000000);
    check("t6_rst_ready", ready_v[0], 1'b1);
    hold(1);
    reset_n = 1'b1;
    hold(4);
    u0c = und_cnt[0];
    ss_on(0);
    check("t6_underrun", und_cnt[0] - u0c, 1);
    ss_off(0);

    // Random words, single and streamed, on both instances
    for (int r = 0; r < 4; r++) begin
      for (int u = 0; u < 2; u++) begin
        w1 = 8'($urandom);
        w2 = 8'($urandom);
        d0 = done_cnt[u]; u0c = und_cnt[u];
        load_word(u, w1);
        ss_on(u);
        pulses(u, 8, got);
        ss_off(u);
        check("rnd_single", got[7:0], exp_seq(w1, u == 0));
        load_word(u, w1);
        ss_on(u);
        pulses(u, 3, got);
        load_word(u, w2);
        pulses(u, 13, got2);
        ss_off(u);
        got = {got2[12:0], got[2:0]};
        check("rnd_stream", got, {exp_seq(w2, u == 0), exp_seq(w1, u == 0)});
        check("rnd_done", done_cnt[u] - d0, 3);
        check("rnd_underrun", und_cnt[u] - u0c, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
